mips_lite_pipe: RTL and testbench

//  Parametrised successor to the single-issue MIPS-subset executor. It accepts one instruction per cycle
//  and executes it against a small sparse register file. It then reports NUM_OUT selected registers, or a

---
 rtl/mips_lite_pkg.sv | 51 +++++
 rtl/mips_lite_alu.sv | 41 ++++
 rtl/mips_lite_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_mips_lite_pipe.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lite_pkg.sv
// Shared opcodes, ALU op encoding and the architectural register map
// for the mips_lite pipeline.
package mips_lite_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_t;

    localparam logic [4:0] REG_MAP [0:7] = '{
        5'd17, 5'd18, 5'd8, 5'd23, 5'd31, 5'd16, 5'd9, 5'd10
    };

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } reg_hit_t;

    // Only the first nregs map entries are architecturally visible.
    function automatic reg_hit_t reg_index(input logic [4:0] addr,
                                           input int nregs);
        reg_hit_t r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (i < nregs && REG_MAP[i] == addr) begin
                r.hit = 1'b1;
                r.idx = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mips_lite_alu.sv
// Combinational ALU for mips_lite_pipe; ovf flags signed overflow
// on add/sub only.
module mips_lite_alu
    import mips_lite_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_t           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [4:0]        i_shamt,
    output logic [DATA_W-1:0] o_result,
    output logic              o_ovf
);

    always_comb begin
        o_result = '0;
        o_ovf    = 1'b0;
        case (i_op)
            ALU_ADD: begin
                o_result = i_a + i_b;
                o_ovf    = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                           (o_result[DATA_W-1] != i_a[DATA_W-1]);
            end
            ALU_SUB: begin
                o_result = i_a - i_b;
                o_ovf    = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                           (o_result[DATA_W-1] != i_a[DATA_W-1]);
            end
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_NOR: o_result = ~(i_a | i_b);
            ALU_SLT: o_result = {{(DATA_W-1){1'b0}},
                                 $signed(i_a) < $signed(i_b)};
            ALU_SLL: o_result = i_b << i_shamt;
            ALU_SRL: o_result = i_b >> i_shamt;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/mips_lite_pipe.sv
// Three-stage MIPS-subset executor with sparse register file readback.
// Define OVF_TRAP_EN to turn signed add/sub/addi overflow into a fail.
module mips_lite_pipe
    import mips_lite_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 6,
    parameter int NUM_OUT  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [31:0]               instruction,
    input  logic [5*NUM_OUT-1:0]      output_reg,
    output logic                      out_valid,
    output logic [DATA_W*NUM_OUT-1:0] out_data,
    output logic                      instruction_fail
);

`ifdef OVF_TRAP_EN
    localparam logic OVF_TRAP = 1'b1;
`else
    localparam logic OVF_TRAP = 1'b0;
`endif
    localparam int IW = 3;

    logic                  r_s1_valid;
    logic [31:0]           r_s1_instr;
    logic [5*NUM_OUT-1:0]  r_s1_oreg;

    logic [5:0]            w_opc;
    logic [5:0]            w_fn;
    logic [4:0]            w_shamt;
    logic [DATA_W-1:0]     w_imm;
    reg_hit_t              w_rs_h;
    reg_hit_t              w_rt_h;
    reg_hit_t              w_rd_h;
    reg_hit_t              w_oh;
    alu_op_t               w_op;
    logic                  w_use_rs;
    logic                  w_use_imm;
    logic                  w_bad_op;
    logic                  w_oreg_ok;
    logic [IW*NUM_OUT-1:0] w_oidx;
    logic [IW-1:0]         w_dst_idx;
    logic                  w_fail;

    logic                  r_s2_valid;
    logic                  r_s2_fail;
    alu_op_t               r_s2_op;
    logic [IW-1:0]         r_s2_rs;
    logic [IW-1:0]         r_s2_rt;
    logic [IW-1:0]         r_s2_dst;
    logic                  r_s2_use_imm;
    logic [DATA_W-1:0]     r_s2_imm;
    logic [4:0]            r_s2_shamt;
    logic [IW*NUM_OUT-1:0] r_s2_oidx;

    logic [DATA_W-1:0]     w_a;
    logic [DATA_W-1:0]     w_b;
    logic [DATA_W-1:0]     w_alu_res;
    logic                  w_ovf;
    logic                  w_ex_fail;
    logic                  w_we;

    logic [DATA_W-1:0]     r_rf [NUM_REGS];
    logic                  r_s3_valid;
    logic                  r_s3_fail;
    logic [IW*NUM_OUT-1:0] r_s3_oidx;
    logic [DATA_W*NUM_OUT-1:0] w_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= '0;
            r_s1_oreg  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            r_s1_instr <= instruction;
            r_s1_oreg  <= output_reg;
        end
    end

    assign w_opc   = r_s1_instr[31:26];
    assign w_fn    = r_s1_instr[5:0];
    assign w_shamt = r_s1_instr[10:6];
    assign w_imm   = DATA_W'($signed(r_s1_instr[15:0]));
    assign w_rs_h  = reg_index(r_s1_instr[25:21], NUM_REGS);
    assign w_rt_h  = reg_index(r_s1_instr[20:16], NUM_REGS);
    assign w_rd_h  = reg_index(r_s1_instr[15:11], NUM_REGS);

    always_comb begin
        w_op      = ALU_ADD;
        w_use_rs  = 1'b1;
        w_use_imm = 1'b0;
        w_bad_op  = 1'b0;
        case (w_opc)
            OP_RTYPE: begin
                case (w_fn)
                    FN_ADD: w_op = ALU_ADD;
                    FN_SUB: w_op = ALU_SUB;
                    FN_AND: w_op = ALU_AND;
                    FN_OR:  w_op = ALU_OR;
                    FN_NOR: w_op = ALU_NOR;
                    FN_SLT: w_op = ALU_SLT;
                    FN_SLL: begin
                        w_op     = ALU_SLL;
                        w_use_rs = 1'b0;
                    end
                    FN_SRL: begin
                        w_op     = ALU_SRL;
                        w_use_rs = 1'b0;
                    end
                    default: w_bad_op = 1'b1;
                endcase
            end
            OP_ADDI: w_use_imm = 1'b1;
            default: w_bad_op = 1'b1;
        endcase
    end

    always_comb begin
        w_oreg_ok = 1'b1;
        w_oidx    = '0;
        w_oh      = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            w_oh = reg_index(r_s1_oreg[5*k +: 5], NUM_REGS);
            w_oreg_ok = w_oreg_ok & w_oh.hit;
            w_oidx[IW*k +: IW] = w_oh.idx;
        end
    end

    // Shifts ignore rs, addi ignores rd; only used fields must be legal.
    assign w_dst_idx = w_use_imm ? w_rt_h.idx : w_rd_h.idx;
    assign w_fail = w_bad_op
                  | (w_use_rs & ~w_rs_h.hit)
                  | ~w_rt_h.hit
                  | (~w_use_imm & ~w_rd_h.hit)
                  | ~w_oreg_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid   <= 1'b0;
            r_s2_fail    <= 1'b0;
            r_s2_op      <= ALU_ADD;
            r_s2_rs      <= '0;
            r_s2_rt      <= '0;
            r_s2_dst     <= '0;
            r_s2_use_imm <= 1'b0;
            r_s2_imm     <= '0;
            r_s2_shamt   <= '0;
            r_s2_oidx    <= '0;
        end else begin
            r_s2_valid   <= r_s1_valid;
            r_s2_fail    <= w_fail;
            r_s2_op      <= w_op;
            r_s2_rs      <= w_rs_h.idx;
            r_s2_rt      <= w_rt_h.idx;
            r_s2_dst     <= w_dst_idx;
            r_s2_use_imm <= w_use_imm;
            r_s2_imm     <= w_imm;
            r_s2_shamt   <= w_shamt;
            r_s2_oidx    <= w_oidx;
        end
    end

    assign w_a = r_rf[r_s2_rs];
    assign w_b = r_s2_use_imm ? r_s2_imm : r_rf[r_s2_rt];

    mips_lite_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .i_op    (r_s2_op),
        .i_a     (w_a),
        .i_b     (w_b),
        .i_shamt (r_s2_shamt),
        .o_result(w_alu_res),
        .o_ovf   (w_ovf)
    );

    assign w_ex_fail = r_s2_fail | (OVF_TRAP & w_ovf);
    assign w_we      = r_s2_valid & ~w_ex_fail;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
            r_s3_valid <= 1'b0;
            r_s3_fail  <= 1'b0;
            r_s3_oidx  <= '0;
        end else begin
            if (w_we) begin
                r_rf[r_s2_dst] <= w_alu_res;
            end
            r_s3_valid <= r_s2_valid;
            r_s3_fail  <= w_ex_fail;
            r_s3_oidx  <= r_s2_oidx;
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            w_rd_data[DATA_W*k +: DATA_W] = r_rf[r_s3_oidx[IW*k +: IW]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            instruction_fail <= 1'b0;
            out_data         <= '0;
        end else begin
            out_valid        <= r_s3_valid;
            instruction_fail <= r_s3_valid & r_s3_fail;
            out_data         <= (r_s3_valid & ~r_s3_fail) ? w_rd_data : '0;
        end
    end

endmodule

// File: tb/tb_mips_lite_pipe.sv
// Bench for mips_lite_pipe: directed scenarios plus random stream
// against a sequential ISA-level model.
module tb_mips_lite_pipe;

`ifdef OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic         v;
        logic         f;
        logic [127:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  instruction = '0;
    logic [19:0]  output_reg = '0;
    logic         out_valid;
    logic [127:0] out_data;
    logic         instruction_fail;

    int errors = 0;
    int checks = 0;

    logic [31:0] mrf [32];
    exp_t        q [$];
    exp_t        e;

    always #5 clk = ~clk;

    mips_lite_pipe dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .instruction     (instruction),
        .output_reg      (output_reg),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .instruction_fail(instruction_fail)
    );

    function automatic logic [31:0] addi(input logic [4:0] rt,
                                         input logic [4:0] rs,
                                         input logic [15:0] imm);
        return {6'b001000, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd,
                                          input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [19:0] orq(input logic [4:0] p3,
                                        input logic [4:0] p2,
                                        input logic [4:0] p1,
                                        input logic [4:0] p0);
        return {p3, p2, p1, p0};
    endfunction

    function automatic bit legal(input logic [4:0] a);
        return a inside {5'd17, 5'd18, 5'd8, 5'd23, 5'd31, 5'd16};
    endfunction

    // Architectural semantics: execute fully, then read back.
    function automatic exp_t model_exec(input logic [31:0] ins,
                                        input logic [19:0] oreg);
        exp_t        r;
        logic [31:0] a, b, res;
        logic [4:0]  rs, rt, rd, dst;
        bit          ok, ovf;
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        a   = mrf[rs];
        b   = mrf[rt];
        r   = '0;
        r.v = 1'b1;
        ok  = 1;
        ovf = 0;
        res = '0;
        dst = rd;
        if (ins[31:26] == 6'h00) begin
            ok = legal(rt) && legal(rd);
            case (ins[5:0])
                6'h20: begin
                    res = a + b;
                    ovf = (a[31] == b[31]) && (res[31] != a[31]);
                    ok  = ok && legal(rs);
                end
                6'h22: begin
                    res = a - b;
                    ovf = (a[31] != b[31]) && (res[31] != a[31]);
                    ok  = ok && legal(rs);
                end
                6'h24: begin res = a & b;    ok = ok && legal(rs); end
                6'h25: begin res = a | b;    ok = ok && legal(rs); end
                6'h27: begin res = ~(a | b); ok = ok && legal(rs); end
                6'h2a: begin
                    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    ok  = ok && legal(rs);
                end
                6'h00: res = b << ins[10:6];
                6'h02: res = b >> ins[10:6];
                default: ok = 0;
            endcase
        end else if (ins[31:26] == 6'h08) begin
            dst = rt;
            b   = {{16{ins[15]}}, ins[15:0]};
            res = a + b;
            ovf = (a[31] == b[31]) && (res[31] != a[31]);
            ok  = legal(rs) && legal(rt);
        end else begin
            ok = 0;
        end
        for (int k = 0; k < 4; k++) ok = ok && legal(oreg[5*k +: 5]);
        if (TRAP && ovf) ok = 0;
        if (!ok) begin
            r.f = 1'b1;
            return r;
        end
        mrf[dst] = res;
        for (int k = 0; k < 4; k++) r.d[32*k +: 32] = mrf[oreg[5*k +: 5]];
        return r;
    endfunction

    task automatic tick(input logic v, input logic [31:0] ins,
                        input logic [19:0] oreg, input logic r);
        exp_t n;
        in_valid    = v;
        instruction = ins;
        output_reg  = oreg;
        rst         = r;
        @(posedge clk);
        if (r) begin
            foreach (mrf[i]) mrf[i] = '0;
            q.delete();
            for (int i = 0; i < 3; i++) q.push_back('0);
            e = '0;
        end else begin
            n = v ? model_exec(ins, oreg) : exp_t'('0);
            q.push_back(n);
            e = q.pop_front();
        end
        #1;
    endtask

    function automatic logic [4:0] rreg();
        logic [29:0] pool;
        pool = {5'd17, 5'd18, 5'd8, 5'd23, 5'd31, 5'd16};
        if ($urandom_range(0, 19) == 0) return 5'($urandom);
        return pool[5*$urandom_range(0, 5) +: 5];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [47:0] fns;
        logic [5:0]  fn;
        int          k;
        fns = {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02};
        k   = $urandom_range(0, 10);
        if (k == 10) return $urandom;
        if (k >= 8) begin
            if ($urandom_range(0, 3) == 0)
                return addi(rreg(), rreg(), 16'($urandom_range(0, 3)) + 16'h7ffd);
            return addi(rreg(), rreg(), 16'($urandom));
        end
        fn = fns[6*k +: 6];
        if (fn == 6'h00 || fn == 6'h02)
            return rtype(5'd0, rreg(), rreg(), 5'($urandom), fn);
        return rtype(rreg(), rreg(), rreg(), 5'd0, fn);
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, addi(5'd17, 5'd17, 16'd1), orq(17, 17, 17, 17), i < 2);
            checks++;
            if ({out_valid, instruction_fail, out_data} !== 130'd0) begin
                errors++;
                $display("FAIL reset[%0d]: got v=%b f=%b d=%h, need all 0",
                         i, out_valid, instruction_fail, out_data);
            end
        end
    endtask

    task automatic test_addi();
        exp_t want;
        tick(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(i == 0, 32'h22310005, orq(8, 23, 18, 17), 1'b0);
            want = (i == 3) ? {1'b1, 1'b0, 96'd0, 32'd5} : exp_t'('0);
            checks++;
            if ({out_valid, instruction_fail, out_data} !== want) begin
                errors++;
                $display("FAIL addi[%0d]: got v=%b f=%b d=%h, need %h",
                         i, out_valid, instruction_fail, out_data, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t want [5];
        want[0] = '0;
        want[1] = '0;
        want[2] = '0;
        want[3] = {1'b1, 1'b0, 64'd0, 32'd0, 32'd5};
        want[4] = {1'b1, 1'b0, 64'd0, 32'd8, 32'd5};
        tick(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(i < 2, (i == 0) ? addi(5'd17, 5'd17, 16'd5)
                                 : addi(5'd18, 5'd17, 16'd3),
                 orq(8, 23, 18, 17), 1'b0);
            checks++;
            if ({out_valid, instruction_fail, out_data} !== want[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got v=%b f=%b d=%h, need %h",
                         i, out_valid, instruction_fail, out_data, want[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [4];
        logic [19:0] orr [4];
        exp_t        want;
        ins[0] = rtype(5'd17, 5'd17, 5'd17, 5'd0, 6'b000001);
        ins[1] = addi(5'd17, 5'd17, 16'd1);
        ins[2] = addi(5'd17, 5'd5, 16'd1);
        ins[3] = addi(5'd23, 5'd23, 16'd0);
        orr[0] = orq(8, 23, 18, 17);
        orr[1] = orq(8, 5, 18, 17);
        orr[2] = orq(8, 23, 18, 17);
        orr[3] = orq(8, 23, 18, 17);
        for (int i = 0; i < 7; i++) begin
            tick(i < 4, ins[i % 4], orr[i % 4], 1'b0);
            if (i >= 3) begin
                want = (i == 6) ? {1'b1, 1'b0, 64'd0, 32'd8, 32'd5}
                                : {1'b1, 1'b1, 128'd0};
                checks++;
                if ({out_valid, instruction_fail, out_data} !== want) begin
                    errors++;
                    $display("FAIL illegal[%0d]: got v=%b f=%b d=%h, need %h",
                             i - 3, out_valid, instruction_fail, out_data, want);
                end
            end
        end
    endtask

    task automatic test_shift_slt();
        logic [31:0] ins [4];
        exp_t        want [4];
        ins[0]  = addi(5'd17, 5'd17, 16'd5);
        ins[1]  = rtype(5'd0, 5'd17, 5'd8, 5'd4, 6'b000000);
        ins[2]  = rtype(5'd8, 5'd17, 5'd23, 5'd0, 6'b101010);
        ins[3]  = rtype(5'd17, 5'd8, 5'd23, 5'd0, 6'b101010);
        want[0] = {1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd5};
        want[1] = {1'b1, 1'b0, 32'd0, 32'd80, 32'd0, 32'd5};
        want[2] = {1'b1, 1'b0, 32'd0, 32'd80, 32'd0, 32'd5};
        want[3] = {1'b1, 1'b0, 32'd1, 32'd80, 32'd0, 32'd5};
        tick(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(i < 4, ins[i % 4], orq(23, 8, 18, 17), 1'b0);
            if (i >= 3) begin
                checks++;
                if ({out_valid, instruction_fail, out_data} !== want[i-3]) begin
                    errors++;
                    $display("FAIL shift_slt[%0d]: got v=%b f=%b d=%h, need %h",
                             i - 3, out_valid, instruction_fail, out_data,
                             want[i-3]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] ins [4];
        exp_t        want [4];
        ins[0]  = addi(5'd17, 5'd17, 16'hffff);
        ins[1]  = rtype(5'd0, 5'd17, 5'd17, 5'd1, 6'b000010);
        ins[2]  = addi(5'd17, 5'd17, 16'd1);
        ins[3]  = addi(5'd23, 5'd23, 16'd0);
        want[0] = {1'b1, 1'b0, 96'd0, 32'hffffffff};
        want[1] = {1'b1, 1'b0, 96'd0, 32'h7fffffff};
        if (TRAP) begin
            want[2] = {1'b1, 1'b1, 128'd0};
            want[3] = {1'b1, 1'b0, 96'd0, 32'h7fffffff};
        end else begin
            want[2] = {1'b1, 1'b0, 96'd0, 32'h80000000};
            want[3] = {1'b1, 1'b0, 96'd0, 32'h80000000};
        end
        tick(1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(i < 4, ins[i % 4], orq(8, 23, 18, 17), 1'b0);
            if (i >= 3) begin
                checks++;
                if ({out_valid, instruction_fail, out_data} !== want[i-3]) begin
                    errors++;
                    $display("FAIL overflow[%0d]: got v=%b f=%b d=%h, need %h",
                             i - 3, out_valid, instruction_fail, out_data,
                             want[i-3]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t want;
        tick(1'b1, addi(5'd18, 5'd17, 16'd1), orq(8, 23, 18, 17), 1'b0);
        tick(1'b1, addi(5'd23, 5'd17, 16'd2), orq(8, 23, 18, 17), 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)
                tick(1'b0, '0, '0, 1'b1);
            else if (i == 5)
                tick(1'b1, addi(5'd23, 5'd23, 16'd0), orq(8, 23, 18, 17), 1'b0);
            else if (i == 6)
                tick(1'b1, addi(5'd23, 5'd23, 16'd0), orq(16, 31, 16, 31), 1'b0);
            else
                tick(1'b0, '0, '0, 1'b0);
            want = (i >= 8) ? {1'b1, 1'b0, 128'd0} : exp_t'('0);
            checks++;
            if ({out_valid, instruction_fail, out_data} !== want) begin
                errors++;
                $display("FAIL reset_mid[%0d]: got v=%b f=%b d=%h, need %h",
                         i, out_valid, instruction_fail, out_data, want);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] o;
        tick(1'b0, '0, '0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            o = {rreg(), rreg(), rreg(), rreg()};
            tick($urandom_range(0, 3) != 0, rand_instr(), o,
                 $urandom_range(0, 59) == 0);
            checks++;
            if ({out_valid, instruction_fail, out_data} !== e) begin
                errors++;
                $display("FAIL random[%0d]: got v=%b f=%b d=%h, need v=%b f=%b d=%h",
                         n, out_valid, instruction_fail, out_data, e.v, e.f, e.d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_shift_slt();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
